// File: rtl/word_serial_subtractor_pkg.sv
// Shared types and constants for the word-serial subtractor and its prefix slice.
package word_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 4;

  // Ceiling log2, never below 1 so a single-word build still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pp_word_sub.sv
// One WORD_W-bit slice computing a + ~b + cin through a Brent-Kung prefix tree.
module pp_word_sub #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  function automatic int pow2_floor(input int n);
    int v;
    v = 1;
    while ((v * 2) <= n) v = v * 2;
    return v;
  endfunction

  localparam int TOP = pow2_floor(WORD_W);

  always_comb begin
    logic [WORD_W-1:0] bn, h, g, p;
    bn = ~b;
    h  = a ^ bn;
    g  = a & bn;
    p  = h;
    // Fold the carry-in into bit 0 so every group generate already covers it.
    g[0] = g[0] | (h[0] & cin);
    for (int d = 1; d < WORD_W; d = d * 2) begin
      for (int i = 2 * d - 1; i < WORD_W; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = TOP / 2; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WORD_W; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    sum    = h;
    sum[0] = h[0] ^ cin;
    for (int i = 1; i < WORD_W; i++) begin
      sum[i] = h[i] ^ g[i-1];
    end
    cout = g[WORD_W-1];
  end

endmodule

// File: rtl/word_serial_subtractor.sv
// Multi-word A - B - borrow_in, one prefix-slice word per clock with a registered borrow chain.
module word_serial_subtractor
  import word_serial_subtractor_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   minuend,
  input  logic [WORD_W*NUM_WORDS-1:0]   subtrahend,
  input  logic                          borrow_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   difference,
  output logic                          borrow_out,
  output logic                          overflow
);

  localparam int W  = WORD_W * NUM_WORDS;
  localparam int KW = clog2_min1(NUM_WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, diff_q;
  logic [KW-1:0]   k_q, k_d;
  logic            c_q, borrow_q, ovf_q, in_ready_q, out_valid_q;
  logic [WORD_W-1:0] a_w, b_w, s_w;
  logic            co_w;

  assign a_w = a_q[int'(k_q) * WORD_W +: WORD_W];
  assign b_w = b_q[int'(k_q) * WORD_W +: WORD_W];
  assign k_d = k_q + 1'b1;

  pp_word_sub #(.WORD_W(WORD_W)) u_slice (
    .a    (a_w),
    .b    (b_w),
    .cin  (c_q),
    .sum  (s_w),
    .cout (co_w)
  );

  // Operands are only needed while RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= minuend;
      b_q <= subtrahend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      c_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            c_q        <= ~borrow_in;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          diff_q[int'(k_q) * WORD_W +: WORD_W] <= s_w;
          c_q <= co_w;
          k_q <= k_d;
          if (k_q == K_LAST) begin
            borrow_q    <= ~co_w;
            ovf_q       <= (a_q[W-1] != b_q[W-1]) & (s_w[WORD_W-1] != a_q[W-1]);
            k_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign difference = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule
